// File: rtl/jt1942_obj_pkg.sv
// jt1942_obj_pkg
// Shared definitions for the object line-draw stage: transparent pixel value,
// attribute byte bit positions, draw FSM state encoding, the slot tick that
// accepts a new object, and small helpers for pixel and height decoding.
package jt1942_obj_pkg;

    localparam logic [3:0] TRANSP_DEF = 4'hF;

    // Bit positions inside objbuf_data1 (attribute byte)
    localparam int ATTR_CODE8   = 7;
    localparam int ATTR_SIZE_HI = 6;
    localparam int ATTR_SIZE_LO = 5;
    localparam int ATTR_X8      = 4;
    localparam int ATTR_PAL_HI  = 3;
    localparam int ATTR_PAL_LO  = 0;

    // The object RAM latch happens at tick 6, so its bytes are stable at tick 7
    localparam logic [3:0] ACCEPT_PXL = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAW  = 2'd3
    } obj_state_e;

    // Pick pixel sel (0 = leftmost) out of a ROM word; MSB nibble is leftmost
    function automatic logic [3:0] obj_nibble(input logic [15:0] word, input logic [1:0] sel);
        logic [3:0] nib;
        case (sel)
            2'd0:    nib = word[15:12];
            2'd1:    nib = word[11:8];
            2'd2:    nib = word[7:4];
            default: nib = word[3:0];
        endcase
        return nib;
    endfunction

    // Object height in lines; the unused size code 3 behaves like size 2
    function automatic logic [6:0] obj_height(input logic [1:0] size);
        logic [6:0] h;
        case (size)
            2'd0:    h = 7'd16;
            2'd1:    h = 7'd32;
            default: h = 7'd64;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/jt1942_obj_vmatch.sv
// jt1942_obj_vmatch
// Purely combinational vertical match for one object.
//   v_i        : render line
//   y_i        : object top line
//   size_i     : object size code (height 16 << size, 3 treated as 2)
//   code_i     : 9-bit object code
//   hit_o      : render line falls inside the object
//   vrel_o     : line offset inside the object (mod 256)
//   code_eff_o : code of the 16-line tile holding that line (9-bit wrap)
module jt1942_obj_vmatch
    import jt1942_obj_pkg::*;
(
    input  logic [7:0] v_i,
    input  logic [7:0] y_i,
    input  logic [1:0] size_i,
    input  logic [8:0] code_i,
    output logic       hit_o,
    output logic [7:0] vrel_o,
    output logic [8:0] code_eff_o
);

    // Offset, hit test and tile selection; tall objects use consecutive codes
    always_comb begin
        vrel_o     = v_i - y_i;
        hit_o      = (vrel_o < {1'b0, obj_height(size_i)});
        code_eff_o = code_i + {7'd0, vrel_o[5:4]};
    end

endmodule

// File: rtl/jt1942_objdraw.sv
// jt1942_objdraw
// Object line-draw stage. Accepts the four latched object bytes once per slot,
// checks them against the render line, fetches the matching 16-pixel row
// (four ROM words) and streams non-transparent, on-screen pixels to the line
// buffer, one per clk.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cen6, pxlcnt      : 6 MHz enable and tick inside the object slot
//   SEATM_b           : low while the object scan owns object RAM
//   V                 : render line being prepared
//   objbuf_data0..3   : code[7:0], attributes, y, x[7:0]
//   rom_addr/cs/data/ok : object ROM word interface
//   pxl_we/addr/data  : line-buffer write port
//   busy, overrun     : activity flag and sticky slot-overlap flag
module jt1942_objdraw
    import jt1942_obj_pkg::*;
#(
    parameter int         ROMW   = 15,
    parameter logic [3:0] TRANSP = TRANSP_DEF
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen6,
    input  logic [7:0]      V,
    input  logic [3:0]      pxlcnt,
    input  logic            SEATM_b,
    input  logic [7:0]      objbuf_data0,
    input  logic [7:0]      objbuf_data1,
    input  logic [7:0]      objbuf_data2,
    input  logic [7:0]      objbuf_data3,
    output logic [ROMW-1:0] rom_addr,
    output logic            rom_cs,
    input  logic [15:0]     rom_data,
    input  logic            rom_ok,
    output logic            pxl_we,
    output logic [7:0]      pxl_addr,
    output logic [7:0]      pxl_data,
    output logic            busy,
    output logic            overrun
);

    obj_state_e      state_q, state_d;
    logic [8:0]      code_q;
    logic [1:0]      size_q;
    logic [8:0]      x_q;
    logic [3:0]      pal_q;
    logic [7:0]      y_q;
    logic [15:0]     buf_q [4];
    logic [1:0]      w_q, w_d;
    logic [3:0]      i_q, i_d;
    logic            rom_cs_q, rom_cs_d;
    logic [ROMW-1:0] rom_addr_q, rom_addr_d;
    logic            pxl_we_q, pxl_we_d;
    logic [7:0]      pxl_addr_q, pxl_addr_d;
    logic [7:0]      pxl_data_q, pxl_data_d;
    logic            busy_q;
    logic            overrun_q, overrun_d;

    logic            accept_s;
    logic            buf_we_s;
    logic            hit_s;
    logic [7:0]      vrel_s;
    logic [8:0]      code_eff_s;
    logic [3:0]      pix_idx_s;
    logic [3:0]      pix_s;
    logic [9:0]      xs_s;
    logic            pix_vis_s;

    assign accept_s = cen6 && !SEATM_b && (pxlcnt == ACCEPT_PXL);

    jt1942_obj_vmatch u_vmatch (
        .v_i        (V),
        .y_i        (y_q),
        .size_i     (size_q),
        .code_i     (code_q),
        .hit_o      (hit_s),
        .vrel_o     (vrel_s),
        .code_eff_o (code_eff_s)
    );

    // Pixel to present next: pixel 0 on the FETCH->DRAW transition, else i+1
    always_comb begin
        if (state_q == ST_DRAW) begin
            pix_idx_s = i_q + 4'd1;
        end else begin
            pix_idx_s = 4'd0;
        end
        pix_s     = obj_nibble(buf_q[pix_idx_s[3:2]], pix_idx_s[1:0]);
        xs_s      = {1'b0, x_q} + {6'd0, pix_idx_s};
        pix_vis_s = (pix_s != TRANSP) && (xs_s[9:8] == 2'b00);
    end

    // Next-state logic; a new accept always wins over whatever is in flight
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        i_d        = i_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        pxl_we_d   = 1'b0;
        pxl_addr_d = pxl_addr_q;
        pxl_data_d = pxl_data_q;
        overrun_d  = overrun_q;
        buf_we_s   = 1'b0;
        if (accept_s) begin
            state_d   = ST_CHECK;
            rom_cs_d  = 1'b0;
            overrun_d = overrun_q | busy_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CHECK: begin
                    if (hit_s) begin
                        state_d    = ST_FETCH;
                        w_d        = 2'd0;
                        rom_cs_d   = 1'b1;
                        rom_addr_d = ROMW'({code_eff_s, vrel_s[3:0], 2'd0});
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (rom_ok) begin
                        buf_we_s   = 1'b1;
                        w_d        = w_q + 2'd1;
                        // Request the next word in the same clk as the capture
                        rom_addr_d = {rom_addr_q[ROMW-1:2], w_q + 2'd1};
                        if (w_q == 2'd3) begin
                            rom_cs_d   = 1'b0;
                            state_d    = ST_DRAW;
                            i_d        = 4'd0;
                            pxl_we_d   = pix_vis_s;
                            pxl_addr_d = xs_s[7:0];
                            pxl_data_d = {pal_q, pix_s};
                        end else begin
                            rom_cs_d = 1'b1;
                        end
                    end else begin
                        rom_cs_d = 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (i_q == 4'd15) begin
                        state_d = ST_IDLE;
                    end else begin
                        i_d        = i_q + 4'd1;
                        pxl_we_d   = pix_vis_s;
                        pxl_addr_d = xs_s[7:0];
                        pxl_data_d = {pal_q, pix_s};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            w_q        <= 2'd0;
            i_q        <= 4'd0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            pxl_we_q   <= 1'b0;
            pxl_addr_q <= 8'd0;
            pxl_data_q <= 8'd0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            i_q        <= i_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            pxl_we_q   <= pxl_we_d;
            pxl_addr_q <= pxl_addr_d;
            pxl_data_q <= pxl_data_d;
            busy_q     <= (state_d != ST_IDLE);
            overrun_q  <= overrun_d;
        end
    end

    // Working copy of the object bytes and the fetched pixel row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= 9'd0;
            size_q <= 2'd0;
            x_q    <= 9'd0;
            pal_q  <= 4'd0;
            y_q    <= 8'd0;
            for (int k = 0; k < 4; k++) begin
                buf_q[k] <= 16'd0;
            end
        end else begin
            if (accept_s) begin
                code_q <= {objbuf_data1[ATTR_CODE8], objbuf_data0};
                size_q <= objbuf_data1[ATTR_SIZE_HI:ATTR_SIZE_LO];
                x_q    <= {objbuf_data1[ATTR_X8], objbuf_data3};
                pal_q  <= objbuf_data1[ATTR_PAL_HI:ATTR_PAL_LO];
                y_q    <= objbuf_data2;
            end
            if (buf_we_s) begin
                buf_q[w_q] <= rom_data;
            end
        end
    end

    assign rom_addr = rom_addr_q;
    assign rom_cs   = rom_cs_q;
    assign pxl_we   = pxl_we_q;
    assign pxl_addr = pxl_addr_q;
    assign pxl_data = pxl_data_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule
